// File: rtl/game_timer_score.sv
// -----------------------------------------------------------------------------
// game_timer_score
//   Game sequencer for the whack-a-mole display. It owns the countdown timer
//   (BCD seconds plus tenths) and the hit score (BCD 000-999), and it drives
//   the NUM / point / nothing inputs of six 7-segment digit decoders.
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        synchronous active-low reset
//   START        one-cycle pulse: start a new game (honoured in IDLE/OVER)
//   HIT          one-cycle pulse: one mole hit (counted in RUN only)
//   PAUSE        level: freezes timer and prescaler while high
//   DIG_NUM      {d5,d4,d3,d2,d1,d0} BCD, d5..d3 = SS.t, d2..d0 = score
//   DIG_POINT    per-digit decimal point, active-low (only d4 lit)
//   DIG_NOTHING  per-digit dash request
//   RUNNING      state is RUN
//   GAME_OVER    state is OVER
// -----------------------------------------------------------------------------
module game_timer_score #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = 60
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        HIT,
  input  logic        PAUSE,
  output logic [23:0] DIG_NUM,
  output logic [5:0]  DIG_POINT,
  output logic [5:0]  DIG_NOTHING,
  output logic        RUNNING,
  output logic        GAME_OVER
);

  // One tick every tenth of a second.
  localparam int PRE_CNT = CLK_HZ / 10;
  localparam int PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_CNT - 1);

  localparam logic [3:0] LOAD_TENS  = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] LOAD_UNITS = 4'(GAME_SECONDS % 10);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [PRE_W-1:0] pre;
  logic [3:0]       sec_tens, sec_units, tenths;
  logic [3:0]       sc_hund, sc_tens, sc_units;

  logic tick;        // prescaler terminal count while running
  logic last_tick;   // the tick that takes the timer from 00.1 to 00.0
  logic timer_zero;
  logic score_max;
  logic load;        // new game: reload timer, clear score and prescaler

  assign tick       = (state == S_RUN) && (pre == PRE_LAST);
  assign timer_zero = (sec_tens == 4'd0) && (sec_units == 4'd0) && (tenths == 4'd0);
  assign last_tick  = tick && (sec_tens == 4'd0) && (sec_units == 4'd0) && (tenths == 4'd1);
  assign score_max  = (sc_hund == 4'd9) && (sc_tens == 4'd9) && (sc_units == 4'd9);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // Next state. The final tick wins over PAUSE so the game always ends on time.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (START) begin
          state_nx = S_RUN;
          load     = 1'b1;
        end
      end
      S_RUN: begin
        if (last_tick)  state_nx = S_OVER;
        else if (PAUSE) state_nx = S_PAUSED;
      end
      S_PAUSED: begin
        if (!PAUSE) state_nx = S_RUN;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler, timer and score. A START in IDLE/OVER reloads everything, and
  // any HIT on that same edge is dropped because the load takes precedence.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pre       <= '0;
      sec_tens  <= LOAD_TENS;
      sec_units <= LOAD_UNITS;
      tenths    <= 4'd0;
      sc_hund   <= 4'd0;
      sc_tens   <= 4'd0;
      sc_units  <= 4'd0;
    end else if (load) begin
      pre       <= '0;
      sec_tens  <= LOAD_TENS;
      sec_units <= LOAD_UNITS;
      tenths    <= 4'd0;
      sc_hund   <= 4'd0;
      sc_tens   <= 4'd0;
      sc_units  <= 4'd0;
    end else if (state == S_RUN) begin
      pre <= tick ? '0 : pre + 1'b1;

      // BCD down-count with borrow; the zero guard keeps it at 00.0.
      if (tick && !timer_zero) begin
        if (tenths != 4'd0) begin
          tenths <= tenths - 4'd1;
        end else begin
          tenths <= 4'd9;
          if (sec_units != 4'd0) begin
            sec_units <= sec_units - 4'd1;
          end else begin
            sec_units <= 4'd9;
            sec_tens  <= sec_tens - 4'd1;
          end
        end
      end

      // BCD up-count with carry, saturating at 999.
      if (HIT && !score_max) begin
        if (sc_units != 4'd9) begin
          sc_units <= sc_units + 4'd1;
        end else begin
          sc_units <= 4'd0;
          if (sc_tens != 4'd9) begin
            sc_tens <= sc_tens + 4'd1;
          end else begin
            sc_tens <= 4'd0;
            sc_hund <= sc_hund + 4'd1;
          end
        end
      end
    end else if (state != S_PAUSED) begin
      // IDLE and OVER keep the prescaler parked at zero.
      pre <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Display outputs, decoded straight from registers.
  // ---------------------------------------------------------------------------
  assign DIG_NUM   = {sec_tens, sec_units, tenths, sc_hund, sc_tens, sc_units};
  assign DIG_POINT = 6'b101111;

  always_comb begin
    DIG_NOTHING = 6'b000000;
    if (state == S_OVER) begin
      DIG_NOTHING[5:3] = 3'b111;
    end else begin
      DIG_NOTHING[5] = (sec_tens == 4'd0);
    end
    // Leading-zero suppression on the score; units always shown.
    DIG_NOTHING[2] = (sc_hund == 4'd0);
    DIG_NOTHING[1] = (sc_hund == 4'd0) && (sc_tens == 4'd0);
  end

  assign RUNNING   = (state == S_RUN);
  assign GAME_OVER = (state == S_OVER);

endmodule

// File: doc/game_timer_score.md
Name: game_timer_score

Overview:
- Upstream feeder for the six 7-segment digit decoders in the whack-a-mole design.
- Owns the game countdown timer (seconds plus tenths, BCD) and the hit score (BCD, 000-999).
- Drives each decoder's NUM, point and nothing inputs directly.
- Sequences the game: idle, run, pause, over.

Parameters:
- CLK_HZ, 50_000_000: CLK frequency. Must be a multiple of 10 and at least 10.
- GAME_SECONDS, 60: game length in whole seconds. Range 1-99.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  single-cycle pulse; starts a new game.
- HIT  in  1  single-cycle pulse; one mole hit.
- PAUSE  in  1  level; freezes the timer while high.
- DIG_NUM  out  24  packed BCD digits {d5,d4,d3,d2,d1,d0}, 4 bits each, d0 = [3:0]. Each field feeds one decoder's NUM.
- DIG_POINT  out  6  per-digit point bit, active-low (0 lights the decimal point).
- DIG_NOTHING  out  6  per-digit blank request (1 makes the decoder show a dash).
- RUNNING  out  1  high in RUN.
- GAME_OVER  out  1  high in OVER.

Behaviour:
- Digit map:
  - d5 = seconds tens, d4 = seconds units, d3 = tenths.
  - d2/d1/d0 = score hundreds/tens/units.
- Point: DIG_POINT = 6'b101111, so only d4 lights its point, giving "SS.t". This is constant in every state.
- Prescaler:
  - Counts 0 to CLK_HZ/10-1 in RUN only.
  - Issues a one-cycle tick on the terminal count and wraps to 0.
  - Holds its value in PAUSED.
  - Clears to 0 in IDLE and OVER, and on START.
- Timer:
  - BCD down-counter {sec_tens, sec_units, tenths}.
  - On each tick, tenths decrements. Borrow chain: 0 -> 9 borrows from units, units 0 -> 9 borrows from tens.
  - Never goes below 00.0.
- Score:
  - BCD up-counter with carry chain 9 -> 0.
  - Increments on HIT only in RUN.
  - Saturates at 999; further HITs are ignored.
- States (registered; reset state IDLE):
  - IDLE: timer loaded with GAME_SECONDS.0, score 000. START -> RUN (score cleared, timer reloaded, prescaler cleared).
  - RUN:
    - PAUSE=1 -> PAUSED.
    - If a tick takes the timer to 00.0 -> OVER on that same edge.
    - START ignored.
  - PAUSED:
    - PAUSE=0 -> RUN.
    - HIT and START ignored.
    - Timer and prescaler frozen.
  - OVER: timer held at 00.0, score held. START -> RUN with the same reload as from IDLE.
- Simultaneous events:
  - HIT on the same edge as the final tick is counted.
  - PAUSE=1 on the same edge as the final tick: OVER takes priority.
  - START plus HIT on the same edge in IDLE/OVER: score ends at 000 (the HIT is dropped).
- Display blanking (combinational from registers, so visible immediately after the updating edge):
  - DIG_NOTHING[5] = 1 when sec_tens == 0 and the state is not OVER.
  - d4 and d3 are never blanked outside OVER.
  - In OVER, DIG_NOTHING[5:3] = 3'b111, so the time field shows three dashes.
  - Score leading-zero blanking: DIG_NOTHING[2] = 1 when hundreds == 0. DIG_NOTHING[1] = 1 when hundreds == 0 and tens == 0. DIG_NOTHING[0] is always 0.
- Outputs RUNNING and GAME_OVER decode the state register with no extra latency.
- Reset values:
  - State IDLE, prescaler 0, score 000, timer GAME_SECONDS.0.
  - RUNNING = 0, GAME_OVER = 0, DIG_POINT = 6'b101111.
  - DIG_NOTHING per the rules above (for GAME_SECONDS=60: 6'b000110).
- Reset mid-game: on the first edge with RST_N=0, all state returns to reset values, regardless of other inputs.
- START pulses wider than one cycle act as a single start, because START is ignored in RUN.

Test Plan:
- Reset value check (CLK_HZ=100, GAME_SECONDS=2): hold RST_N=0 for 2 cycles, release -> DIG_NUM=24'h020000, DIG_NOTHING=6'b100110, DIG_POINT=6'b101111, RUNNING=0, GAME_OVER=0.
- Full countdown (same params): START pulse -> RUNNING=1 next cycle. After 10 cycles the timer reads 01.9. After 200 cycles GAME_OVER=1, RUNNING=0, DIG_NUM[23:12]=12'h000, DIG_NOTHING[5:3]=3'b111.
- Score carry and saturation (GAME_SECONDS=99, CLK_HZ=50_000_000): 9 HITs -> d0=9, DIG_NOTHING[2:0]=3'b110. 10th HIT -> 010, DIG_NOTHING[2:0]=3'b100. 1005 HITs total -> score 999 and stays there.
- Pause (CLK_HZ=100, GAME_SECONDS=2): after 15 RUN cycles assert PAUSE for 50 cycles -> timer stays at 01.9, HITs are ignored. Release -> next tick after 5 more cycles gives 01.8.
- Final-tick corner: HIT and PAUSE both asserted on the edge that reaches 00.0 -> GAME_OVER=1, score incremented by 1. Then START -> score 000, timer 02.0, RUNNING=1.
- Mid-game reset: drive RST_N=0 for 1 cycle while in RUN with score 005 -> the next cycle matches the reset-value check exactly.
